serial_mux_arbiter: RTL and testbench



---
 rtl/serial_mux_pkg.sv | 26 ++
 rtl/serial_mux_arbiter_if.sv | 27 ++
 rtl/serial_mux_arbiter_rr_pick.sv | 26 ++
 rtl/serial_mux_arbiter.sv | 103 ++++++++++
 tb/tb_serial_mux_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_mux_pkg.sv
// Shared types and sizing helpers for the serial mux arbiter.
// The localparams here describe the default 4 x 40-bit -> 16-bit build.
package serial_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  // Number of output beats needed to carry one input word.
  function automatic int ser_depth(input int nin, input int nout);
    return (nin + nout - 1) / nout;
  endfunction

  function automatic int cnt_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  localparam int NCH_DEF  = 4;
  localparam int NIN_DEF  = 40;
  localparam int NOUT_DEF = 16;
  localparam int ID_W     = $clog2(NCH_DEF);
  localparam int BEAT_W   = cnt_width(ser_depth(NIN_DEF, NOUT_DEF));

endpackage

// File: rtl/serial_mux_arbiter_if.sv
// Requester channels and the serialized link of the serial mux arbiter.
// Every channel is valid/ready: a beat moves on a cycle where v && a; the
// sender holds v and d stable until that cycle, and a may depend on v.
interface serial_mux_arbiter_if #(
  parameter int NCH  = 4,
  parameter int NIN  = 40,
  parameter int NOUT = 16
);

  logic [NCH-1:0]  in_v;
  logic [NCH-1:0]  in_a;
  logic [NIN-1:0]  in_d [NCH];
  logic            out_v;
  logic            out_a;
  logic [NOUT-1:0] out_d;

  modport master (
    output in_v, in_d, out_a,
    input  in_a, out_v, out_d
  );

  modport slave (
    input  in_v, in_d, out_a,
    output in_a, out_v, out_d
  );

endinterface

// File: rtl/serial_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching cyclically.
module rr_pick #(
  parameter  int NCH = 4,
  localparam int IDW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr) + i) % NCH);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/serial_mux_arbiter.sv
// Round-robin arbiter that sends a source-ID header and then the granted
// word LSB-first over one narrow link, holding the grant for the whole word.
module serial_mux_arbiter
  import serial_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int NIN  = 40,
  parameter int NOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  serial_mux_arbiter_if.slave  bus,
  output state_t               state_dbg
);

  localparam int D   = ser_depth(NIN, NOUT);
  localparam int IDW = $clog2(NCH);
  localparam int BW  = cnt_width(D);
  localparam int PW  = D * NOUT;

  state_t          state_q, state_d;
  logic [IDW-1:0]  g_q, g_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [PW-1:0]   word_pad;
  logic [NOUT-1:0] beats [D];
  logic            last_beat;
  logic            body_xfer;

  rr_pick #(.NCH(NCH)) u_pick (
    .req (bus.in_v),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Zero-extending to D full beats gives the short last beat for free.
  assign word_pad = PW'(bus.in_d[g_q]);

  for (genvar b = 0; b < D; b++) begin : g_beat
    assign beats[b] = word_pad[b*NOUT +: NOUT];
  end

  assign last_beat = (beat_q == BW'(D - 1));
  assign body_xfer = bus.in_v[g_q] && bus.out_a;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      beat_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    beat_d    = beat_q;
    ptr_d     = ptr_q;
    bus.out_v = 1'b0;
    bus.out_d = '0;
    bus.in_a  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          g_d     = pick_idx;
          beat_d  = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        bus.out_v = 1'b1;
        bus.out_d = NOUT'(g_q);
        if (bus.out_a) state_d = BODY;
      end
      BODY: begin
        bus.out_v = bus.in_v[g_q];
        bus.out_d = beats[beat_q];
        if (body_xfer) begin
          if (last_beat) begin
            // Ack rides the final transfer; priority moves only on completion.
            bus.in_a[g_q] = 1'b1;
            ptr_d         = (g_q == IDW'(NCH - 1)) ? '0 : g_q + 1'b1;
            state_d       = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_mux_arbiter.sv
// Bench for serial_mux_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a queue-based link model.
module tb_serial_mux_arbiter;
  import serial_mux_pkg::*;

  localparam int NCH  = 4;
  localparam int NIN  = 40;
  localparam int NOUT = 16;
  localparam int D    = 3;

  logic   clk = 1'b0;
  logic   reset_n = 1'b1;
  state_t state_dbg;
  int     n_vec = 0;
  int     n_err = 0;

  serial_mux_arbiter_if #(.NCH(NCH), .NIN(NIN), .NOUT(NOUT)) bus();

  serial_mux_arbiter #(.NCH(NCH), .NIN(NIN), .NOUT(NOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // scoreboard: expected beats of the word in flight
  logic [NOUT-1:0] exp_q[$];
  int              m_g;
  int              m_ptr;
  int              m_k;
  logic [NCH-1:0]  m_ea;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_ptr = 0;
      m_g   = 0;
      check("rst_out_v", bus.out_v, 0);
      check("rst_out_d", bus.out_d, 0);
      check("rst_in_a",  bus.in_a,  0);
    end else if (exp_q.size() == 0) begin
      check("idle_out_v", bus.out_v, 0);
      check("idle_out_d", bus.out_d, 0);
      check("idle_in_a",  bus.in_a,  0);
      for (int i = 0; i < NCH; i++) begin
        m_k = (m_ptr + i) % NCH;
        if (bus.in_v[m_k] && exp_q.size() == 0) begin
          m_g = m_k;
          exp_q.push_back(NOUT'(m_k));
          for (int b = 0; b < D; b++) exp_q.push_back(NOUT'(bus.in_d[m_k] >> (NOUT * b)));
        end
      end
    end else begin
      m_ea = (exp_q.size() == 1 && bus.out_a) ? (NCH'(1) << m_g) : '0;
      check("link_out_v", bus.out_v, 1);
      check("link_out_d", bus.out_d, exp_q[0]);
      check("link_in_a",  bus.in_a,  m_ea);
      if (bus.out_a) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_ptr = (m_g + 1) % NCH;
      end
    end
  end

  // driver tasks
  task automatic wait_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic ev, input logic [15:0] ed, input logic [3:0] ea, input string nm);
    @(negedge clk);
    check({nm, "_v"}, bus.out_v, ev);
    check({nm, "_d"}, bus.out_d, ed);
    check({nm, "_a"}, bus.in_a,  ea);
  endtask

  task automatic do_reset();
    wait_pos();
    reset_n  = 1'b0;
    bus.in_v = '0;
    wait_pos();
    reset_n  = 1'b1;
  endtask

  logic [15:0] hdr_q[$];
  int          hdr_t[$];

  task automatic collect(input int ncyc, input logic [3:0] drop);
    logic       prev_v;
    logic [3:0] ack;
    prev_v = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      ack = bus.in_a;
      if (bus.out_v && !prev_v) begin
        hdr_q.push_back(bus.out_d);
        hdr_t.push_back(i);
      end
      prev_v = bus.out_v;
      wait_pos();
      bus.in_v = bus.in_v & ~(ack & drop);
    end
  endtask

  logic [3:0] r_ack;

  initial begin
    bus.in_v  = '0;
    bus.out_a = 1'b0;
    for (int k = 0; k < NCH; k++) bus.in_d[k] = '0;
    #1 reset_n = 1'b0;
    #2;
    check("por_out_v", bus.out_v, 0);
    check("por_in_a",  bus.in_a,  0);
    check("por_state", state_dbg, IDLE);
    wait_pos();
    reset_n = 1'b1;

    // single source, no backpressure
    bus.out_a    = 1'b1;
    bus.in_d[2]  = 40'hAB_CDEF_0123;
    bus.in_v[2]  = 1'b1;
    chk(1'b0, 16'h0000, 4'b0000, "t1_arb");
    wait_pos(); chk(1'b1, 16'h0002, 4'b0000, "t1_hdr");
    wait_pos(); chk(1'b1, 16'h0123, 4'b0000, "t1_b0");
    wait_pos(); chk(1'b1, 16'hCDEF, 4'b0000, "t1_b1");
    wait_pos(); chk(1'b1, 16'h00AB, 4'b0100, "t1_b2");
    wait_pos(); bus.in_v[2] = 1'b0;
    chk(1'b0, 16'h0000, 4'b0000, "t1_done");

    // backpressure during beat 1
    do_reset();
    bus.out_a   = 1'b1;
    bus.in_v[2] = 1'b1;
    chk(1'b0, 16'h0000, 4'b0000, "bp_arb");
    wait_pos(); chk(1'b1, 16'h0002, 4'b0000, "bp_hdr");
    wait_pos(); chk(1'b1, 16'h0123, 4'b0000, "bp_b0");
    for (int i = 0; i < 3; i++) begin
      wait_pos(); bus.out_a = 1'b0;
      chk(1'b1, 16'hCDEF, 4'b0000, "bp_stall");
      check("bp_state", state_dbg, BODY);
    end
    wait_pos(); bus.out_a = 1'b1;
    chk(1'b1, 16'hCDEF, 4'b0000, "bp_b1");
    wait_pos(); chk(1'b1, 16'h00AB, 4'b0100, "bp_b2");
    wait_pos(); bus.in_v[2] = 1'b0;
    chk(1'b0, 16'h0000, 4'b0000, "bp_done");

    // reset mid-word
    do_reset();
    bus.out_a   = 1'b1;
    bus.in_d[1] = 40'h12_3456_789A;
    bus.in_v[1] = 1'b1;
    chk(1'b0, 16'h0000, 4'b0000, "rm_arb");
    wait_pos(); chk(1'b1, 16'h0001, 4'b0000, "rm_hdr");
    wait_pos(); chk(1'b1, 16'h789A, 4'b0000, "rm_b0");
    wait_pos(); reset_n = 1'b0;
    #1;
    check("rm_rst_v", bus.out_v, 0);
    check("rm_rst_a", bus.in_a,  0);
    check("rm_rst_s", state_dbg, IDLE);
    wait_pos(); reset_n = 1'b1;
    chk(1'b0, 16'h0000, 4'b0000, "rm_rearb");
    wait_pos(); chk(1'b1, 16'h0001, 4'b0000, "rm_hdr2");
    wait_pos(); chk(1'b1, 16'h789A, 4'b0000, "rm_b0b");
    wait_pos(); chk(1'b1, 16'h3456, 4'b0000, "rm_b1b");
    wait_pos(); chk(1'b1, 16'h0012, 4'b0010, "rm_b2b");
    wait_pos(); bus.in_v[1] = 1'b0;

    // fairness with all sources continuously valid
    do_reset();
    bus.out_a = 1'b1;
    for (int k = 0; k < NCH; k++) bus.in_d[k] = NIN'({$urandom, $urandom});
    bus.in_v = 4'b1111;
    hdr_q.delete(); hdr_t.delete();
    collect(30, 4'b0000);
    check("fair_nhdr", hdr_q.size(), 6);
    for (int i = 0; i < hdr_q.size() && i < 6; i++) check("fair_id", hdr_q[i], i % NCH);
    for (int i = 1; i < hdr_t.size() && i < 6; i++) check("fair_gap", hdr_t[i] - hdr_t[i-1], 5);

    // pointer wrap after a word from source 3
    do_reset();
    bus.out_a   = 1'b1;
    bus.in_d[3] = NIN'({$urandom, $urandom});
    bus.in_v[3] = 1'b1;
    hdr_q.delete(); hdr_t.delete();
    collect(5, 4'b1111);
    check("wrap_n1", hdr_q.size(), 1);
    if (hdr_q.size() > 0) check("wrap_first", hdr_q[0], 3);
    hdr_q.delete(); hdr_t.delete();
    bus.in_d[0] = NIN'({$urandom, $urandom});
    bus.in_v[0] = 1'b1;
    bus.in_v[3] = 1'b1;
    collect(11, 4'b1111);
    check("wrap_n2", hdr_q.size(), 2);
    if (hdr_q.size() > 1) begin
      check("wrap_a", hdr_q[0], 0);
      check("wrap_b", hdr_q[1], 3);
    end

    // spurious ack with nothing valid
    do_reset();
    bus.out_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk(1'b0, 16'h0000, 4'b0000, "spur");
      check("spur_state", state_dbg, IDLE);
      wait_pos();
    end

    // randomized traffic, backpressure and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_ack = bus.in_a;
      wait_pos();
      bus.in_v = bus.in_v & ~r_ack;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (!bus.in_v[k] && $urandom_range(0, 2) == 0) begin
          bus.in_d[k] = NIN'({$urandom, $urandom});
          bus.in_v[k] = 1'b1;
        end
      end
      bus.out_a = ($urandom_range(0, 3) != 0);
    end

    wait_pos();
    wait_pos();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
